// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Request/response and RAM-drive bundle for mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [31:0]           i_req_addr;
    logic                  i_rsp_valid;
    logic [DATA_WIDTH-1:0] i_rsp_data;
    logic                  i_rsp_err;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic                  d_req_we;
    logic [31:0]           d_req_addr;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic                  d_rsp_valid;
    logic [DATA_WIDTH-1:0] d_rsp_data;
    logic                  d_rsp_err;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Environment side: requesters plus the RAM.
    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output mem_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_we, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  mem_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares a single-port word RAM between fetch (I) and load/store
//             (D); D has priority, a starvation counter guarantees I progress.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    localparam int                 c_CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0]    r_starve_cnt;
    logic                  r_i_rsp_valid;
    logic                  r_i_rsp_err;
    logic [DATA_WIDTH-1:0] r_i_rsp_data;
    logic                  r_d_rsp_valid;
    logic                  r_d_rsp_err;
    logic [DATA_WIDTH-1:0] r_d_rsp_data;

    logic                  w_i_prio;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_accept;
    logic [31:0]           w_addr;
    logic                  w_err;
    logic                  w_store;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    // Grants are gated by rst so nothing is accepted while reset is held.
    always_comb begin
        w_i_prio   = (r_starve_cnt == c_STARVE_MAX);
        w_grant_i  = !rst && bus.i_req_valid && (!bus.d_req_valid || w_i_prio);
        w_grant_d  = !rst && bus.d_req_valid && !w_grant_i;
        w_accept   = w_grant_i || w_grant_d;
        w_addr     = w_grant_i ? bus.i_req_addr : bus.d_req_addr;
        w_err      = w_accept && ((w_addr[1:0] != 2'b00) ||
                                  ((w_addr >> (ADDR_WIDTH + 2)) != 32'd0));
        w_store    = w_grant_d && bus.d_req_we;
        w_rsp_data = (w_accept && !w_err && !w_store) ? bus.mem_rdata : '0;
    end

    assign bus.i_req_ready = w_grant_i;
    assign bus.d_req_ready = w_grant_d;
    assign bus.mem_we      = w_store && !w_err;
    assign bus.mem_addr    = w_accept ? w_addr[ADDR_WIDTH+1:2] : '0;
    assign bus.mem_wdata   = w_grant_d ? bus.d_req_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_i) begin
            r_starve_cnt <= '0;
        end else if (bus.i_req_valid && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rsp_valid <= 1'b0;
            r_i_rsp_err   <= 1'b0;
            r_i_rsp_data  <= '0;
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_err   <= 1'b0;
            r_d_rsp_data  <= '0;
        end else begin
            r_i_rsp_valid <= w_grant_i;
            r_i_rsp_err   <= w_grant_i && w_err;
            r_i_rsp_data  <= w_grant_i ? w_rsp_data : '0;
            r_d_rsp_valid <= w_grant_d;
            r_d_rsp_err   <= w_grant_d && w_err;
            r_d_rsp_data  <= w_grant_d ? w_rsp_data : '0;
        end
    end

    // Masking with rst drops a response that is in flight when reset arrives.
    assign bus.i_rsp_valid = r_i_rsp_valid && !rst;
    assign bus.i_rsp_err   = r_i_rsp_err && !rst;
    assign bus.i_rsp_data  = rst ? '0 : r_i_rsp_data;
    assign bus.d_rsp_valid = r_d_rsp_valid && !rst;
    assign bus.d_rsp_err   = r_d_rsp_err && !rst;
    assign bus.d_rsp_data  = rst ? '0 : r_d_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed and randomized bench for mem_port_arbiter against a
//             word-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int          c_AW     = 10;
    localparam int          c_LIMIT  = 4;
    localparam int          c_WORDS  = 1 << c_AW;
    localparam logic [31:0] c_BYTES  = 32'(4 << c_AW);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH   (c_AW),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (c_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Environment RAM: combinational read, registered write.
    logic [31:0] ram [c_WORDS];
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

    // Reference model state.
    logic [31:0] model_ram [c_WORDS];
    int          i_wait   = 0;
    logic        exp_iv   = 1'b0;
    logic        exp_dv   = 1'b0;
    logic        exp_err  = 1'b0;
    logic [31:0] exp_data = 32'd0;
    logic        last_gi  = 1'b0;
    logic        last_gd  = 1'b0;
    logic        obs_iready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, then advance.
    task automatic cycle(input logic r, input logic iv, input logic [31:0] ia,
                         input logic dv, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd);
        logic        gi, gd, err;
        logic [31:0] addr, word;
        bus.i_req_valid = iv;
        bus.i_req_addr  = ia;
        bus.d_req_valid = dv;
        bus.d_req_we    = dwe;
        bus.d_req_addr  = da;
        bus.d_req_wdata = dwd;
        rst             = r;
        #4;
        check("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(!r && exp_iv));
        check("i_rsp_err",   32'(bus.i_rsp_err),   32'(!r && exp_iv && exp_err));
        check("i_rsp_data",  bus.i_rsp_data, (!r && exp_iv) ? exp_data : 32'd0);
        check("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(!r && exp_dv));
        check("d_rsp_err",   32'(bus.d_rsp_err),   32'(!r && exp_dv && exp_err));
        check("d_rsp_data",  bus.d_rsp_data, (!r && exp_dv) ? exp_data : 32'd0);

        gi   = !r && iv && (!dv || i_wait >= c_LIMIT);
        gd   = !r && dv && !gi;
        addr = gi ? ia : da;
        err  = (gi || gd) && ((addr % 4 != 0) || (addr >= c_BYTES));
        word = (addr / 4) % c_WORDS;
        obs_iready = bus.i_req_ready;
        check("i_req_ready", 32'(bus.i_req_ready), 32'(gi));
        check("d_req_ready", 32'(bus.d_req_ready), 32'(gd));
        check("mem_we",      32'(bus.mem_we),      32'(gd && dwe && !err));
        check("mem_addr",    32'(bus.mem_addr),    (gi || gd) ? word : 32'd0);
        check("mem_wdata",   bus.mem_wdata,        gd ? dwd : 32'd0);

        exp_iv   = gi;
        exp_dv   = gd;
        exp_err  = err;
        exp_data = ((gi || gd) && !err && !(gd && dwe)) ? model_ram[word] : 32'd0;
        if (gd && dwe && !err) model_ram[word] = dwd;
        if (r || gi)   i_wait = 0;
        else if (iv)   i_wait = (i_wait + 1 > c_LIMIT) ? c_LIMIT : i_wait + 1;
        last_gi = gi;
        last_gd = gd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel  = $urandom_range(0, 15);
        int unsigned word = $urandom_range(0, 31);
        if (sel == 0) return 32'(word * 4 + $urandom_range(1, 3));
        if (sel == 1) return 32'(c_BYTES + word * 4);
        return 32'(word * 4);
    endfunction

    initial begin
        logic [9:0]  grants;
        logic        ip, dp, dwe;
        logic [31:0] ia, da, dwd;

        for (int i = 0; i < c_WORDS; i++) begin
            ram[i]       = $urandom;
            model_ram[i] = ram[i];
        end
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h10, 1, 0, 32'h20, 0);

        // T3: both requesters valid for 10 cycles.
        grants = '0;
        for (int c = 0; c < 10; c++) begin
            cycle(0, 1, 32'h40, 1, 0, 32'h44, 0);
            grants[c] = obs_iready;
        end
        check("t3_grant_pattern", 32'(grants), 32'h210);

        // T1: fetch from word 4.
        ram[4] = 32'hDEAD_BEEF;
        model_ram[4] = 32'hDEAD_BEEF;
        cycle(0, 1, 32'h10, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // T2: store then load of the same word.
        cycle(0, 0, 0, 1, 1, 32'h20, 32'h1234_5678);
        cycle(0, 0, 0, 1, 0, 32'h20, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("t2_ram_word8", ram[8], 32'h1234_5678);

        // T4: misaligned store and out-of-range load.
        cycle(0, 0, 0, 1, 1, 32'h2, 32'hA5A5_A5A5);
        cycle(0, 0, 0, 1, 0, 32'h1000, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("t4_ram_word0", ram[0], model_ram[0]);

        // T5: build up starvation, accept I, then reset with I's response in flight.
        cycle(0, 1, 32'h8, 1, 0, 32'hC, 0);
        cycle(0, 1, 32'h8, 1, 0, 32'hC, 0);
        cycle(0, 0, 0, 1, 0, 32'hC, 0);
        cycle(0, 1, 32'h8, 0, 0, 0, 0);
        cycle(1, 1, 32'h8, 1, 1, 32'hC, 32'hFFFF_FFFF);
        cycle(1, 1, 32'h8, 1, 1, 32'hC, 32'hFFFF_FFFF);
        grants = '0;
        for (int c = 0; c < 5; c++) begin
            cycle(0, 1, 32'h8, 1, 0, 32'hC, 0);
            grants[c] = obs_iready;
        end
        check("t5_starve_cleared", 32'(grants), 32'h010);

        // T6: randomized traffic, requests held until accepted.
        ip = 0; dp = 0; ia = 0; da = 0; dwe = 0; dwd = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!ip) begin
                ip = 1'($urandom_range(0, 1));
                ia = rand_addr();
            end
            if (!dp) begin
                dp  = 1'($urandom_range(0, 1));
                da  = rand_addr();
                dwe = 1'($urandom_range(0, 1));
                dwd = $urandom;
            end
            cycle(($urandom_range(0, 499) == 0), ip, ia, dp, dwe, da, dwd);
            if (last_gi) ip = 0;
            if (last_gd) dp = 0;
        end
        cycle(0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
